// File: rtl/mcycle_seq.sv
// Machine-cycle sequencer: decodes the fetched opcode into a per-instruction
// bus-cycle schedule and steps through it on each machine-cycle end pulse.
module mcycle_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       opvalid,
    input  logic       mcend,
    input  logic       resume,
    output logic [2:0] status,
    output logic [2:0] mcnum,
    output logic       firstmc,
    output logic       lastmc,
    output logic       go6,
    output logic       halt
);

    localparam logic [2:0] C_OF  = 3'd0;
    localparam logic [2:0] C_MR  = 3'd1;
    localparam logic [2:0] C_MW  = 3'd2;
    localparam logic [2:0] C_IOR = 3'd3;
    localparam logic [2:0] C_IOW = 3'd4;
    localparam logic [2:0] C_BI  = 3'd5;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t          r_state;
    logic [2:0]      r_len;
    logic [4:1][2:0] r_list;
    logic            r_hflag;
    logic [2:0]      r_status;
    logic [2:0]      r_mcnum;
    logic            r_lastmc;
    logic            r_go6;
    logic            r_halt;

    logic [2:0]      w_dec_len;
    logic [4:1][2:0] w_dec_list;
    logic            w_dec_go6;
    logic            w_dec_hlt;

    state_t          w_state_next;
    logic [2:0]      w_len_next;
    logic [4:1][2:0] w_list_next;
    logic            w_hflag_next;
    logic [2:0]      w_status_next;
    logic [2:0]      w_mcnum_next;
    logic            w_lastmc_next;
    logic            w_go6_next;
    logic            w_halt_next;
    logic            w_finish;
    logic            w_finish_halt;

    logic [2:0]      w_eff_len;
    logic [2:0]      w_eff_first;
    logic            w_eff_hflag;
    logic [2:0]      w_mc_inc;

    // Opcode decode; the order of tests resolves the overlapping bit patterns.
    always_comb begin
        w_dec_len  = 3'd1;
        w_dec_list = {4{C_OF}};
        w_dec_go6  = 1'b0;
        w_dec_hlt  = 1'b0;
        if (opcode == 8'h76) begin
            w_dec_hlt = 1'b1;
        end else if (opcode == 8'h34 || opcode == 8'h35 || opcode == 8'h36) begin
            w_dec_len     = 3'd3;
            w_dec_list[1] = C_MR;
            w_dec_list[2] = C_MW;
        end else if ((opcode & 8'hC7) == 8'h06 || (opcode & 8'hC7) == 8'h46 ||
                     (opcode & 8'hC7) == 8'h86 || (opcode & 8'hC7) == 8'hC6) begin
            w_dec_len     = 3'd2;
            w_dec_list[1] = C_MR;
        end else if ((opcode & 8'hF8) == 8'h70) begin
            w_dec_len     = 3'd2;
            w_dec_list[1] = C_MW;
        end else if ((opcode & 8'hCF) == 8'h03 || (opcode & 8'hCF) == 8'h0B ||
                     opcode == 8'hF9 || opcode == 8'hE9) begin
            w_dec_go6 = 1'b1;
        end else if ((opcode & 8'hCF) == 8'h01 || (opcode & 8'hCF) == 8'hC1 ||
                     opcode == 8'hC3 || opcode == 8'hC9) begin
            w_dec_len     = 3'd3;
            w_dec_list[1] = C_MR;
            w_dec_list[2] = C_MR;
        end else if (opcode == 8'h3A || opcode == 8'h32) begin
            w_dec_len     = 3'd4;
            w_dec_list[1] = C_MR;
            w_dec_list[2] = C_MR;
            w_dec_list[3] = (opcode == 8'h3A) ? C_MR : C_MW;
        end else if (opcode == 8'h2A || opcode == 8'h22 || opcode == 8'hCD) begin
            w_dec_len     = 3'd5;
            w_dec_go6     = (opcode == 8'hCD);
            w_dec_list[1] = C_MR;
            w_dec_list[2] = C_MR;
            w_dec_list[3] = (opcode == 8'h2A) ? C_MR : C_MW;
            w_dec_list[4] = (opcode == 8'h2A) ? C_MR : C_MW;
        end else if ((opcode & 8'hCF) == 8'hC5) begin
            w_dec_len     = 3'd3;
            w_dec_go6     = 1'b1;
            w_dec_list[1] = C_MW;
            w_dec_list[2] = C_MW;
        end else if (opcode == 8'hDB || opcode == 8'hD3) begin
            w_dec_len     = 3'd3;
            w_dec_list[1] = C_MR;
            w_dec_list[2] = (opcode == 8'hDB) ? C_IOR : C_IOW;
        end else if ((opcode & 8'hCF) == 8'h09) begin
            w_dec_len     = 3'd3;
            w_dec_list[1] = C_BI;
            w_dec_list[2] = C_BI;
        end
    end

    // A decode arriving with mcend in the same clock decides the end of the OF cycle.
    assign w_eff_len   = opvalid ? w_dec_len     : r_len;
    assign w_eff_first = opvalid ? w_dec_list[1] : r_list[1];
    assign w_eff_hflag = opvalid ? w_dec_hlt     : r_hflag;
    assign w_mc_inc    = r_mcnum + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_len    <= 3'd1;
            r_hflag  <= 1'b0;
            r_status <= C_OF;
            r_mcnum  <= 3'd0;
            r_lastmc <= 1'b0;
            r_go6    <= 1'b0;
            r_halt   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_len    <= w_len_next;
            r_hflag  <= w_hflag_next;
            r_status <= w_status_next;
            r_mcnum  <= w_mcnum_next;
            r_lastmc <= w_lastmc_next;
            r_go6    <= w_go6_next;
            r_halt   <= w_halt_next;
        end
    end

    generate
        for (genvar gi = 1; gi <= 4; gi++) begin : g_list
            always_ff @(posedge clock) begin
                if (reset)
                    r_list[gi] <= C_OF;
                else
                    r_list[gi] <= w_list_next[gi];
            end
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_len_next    = r_len;
        w_list_next   = r_list;
        w_hflag_next  = r_hflag;
        w_status_next = r_status;
        w_mcnum_next  = r_mcnum;
        w_lastmc_next = r_lastmc;
        w_go6_next    = r_go6;
        w_halt_next   = r_halt;
        w_finish      = 1'b0;
        w_finish_halt = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (opvalid) begin
                    w_len_next    = w_dec_len;
                    w_list_next   = w_dec_list;
                    w_hflag_next  = w_dec_hlt;
                    w_go6_next    = w_dec_go6;
                    w_lastmc_next = (w_dec_len == 3'd1);
                end
                if (mcend) begin
                    if (w_eff_len == 3'd1) begin
                        w_finish      = 1'b1;
                        w_finish_halt = w_eff_hflag;
                    end else begin
                        w_state_next  = S_EXEC;
                        w_mcnum_next  = 3'd1;
                        w_status_next = w_eff_first;
                        w_lastmc_next = (w_eff_len == 3'd2);
                        w_go6_next    = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                if (mcend) begin
                    if (r_lastmc) begin
                        w_finish      = 1'b1;
                        w_finish_halt = r_hflag;
                    end else begin
                        w_mcnum_next  = w_mc_inc;
                        w_status_next = r_list[w_mc_inc];
                        w_lastmc_next = (w_mc_inc == r_len - 3'd1);
                        w_go6_next    = 1'b0;
                    end
                end
            end
            S_HALT: begin
                if (resume) begin
                    w_state_next = S_FETCH;
                    w_halt_next  = 1'b0;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
        // Ending an instruction drops the decode so a stray mcend in FETCH acts as L=1.
        if (w_finish) begin
            w_state_next  = w_finish_halt ? S_HALT : S_FETCH;
            w_halt_next   = w_finish_halt;
            w_mcnum_next  = 3'd0;
            w_status_next = C_OF;
            w_lastmc_next = 1'b0;
            w_go6_next    = 1'b0;
            w_len_next    = 3'd1;
            w_hflag_next  = 1'b0;
        end
    end

    always_comb begin
        status  = r_status;
        mcnum   = r_mcnum;
        firstmc = (r_mcnum == 3'd0);
        lastmc  = r_lastmc;
        go6     = r_go6;
        halt    = r_halt;
    end

endmodule

// File: tb/tb_mcycle_seq.sv
// Bench for mcycle_seq: table of opcodes with reference cycle schedules plus
// hand-written sequences for reset, HLT and same-clock opvalid/mcend cases.
module tb_mcycle_seq;

    localparam logic [2:0] OF = 3'd0;
    localparam logic [2:0] MR = 3'd1;
    localparam logic [2:0] MW = 3'd2;
    localparam logic [2:0] IR = 3'd3;
    localparam logic [2:0] IW = 3'd4;
    localparam logic [2:0] BI = 3'd5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] opcode = 8'h00;
    logic       opvalid = 1'b0;
    logic       mcend = 1'b0;
    logic       resume = 1'b0;
    logic [2:0] status;
    logic [2:0] mcnum;
    logic       firstmc;
    logic       lastmc;
    logic       go6;
    logic       halt;

    mcycle_seq dut (
        .clock   (clock),
        .reset   (reset),
        .opcode  (opcode),
        .opvalid (opvalid),
        .mcend   (mcend),
        .resume  (resume),
        .status  (status),
        .mcnum   (mcnum),
        .firstmc (firstmc),
        .lastmc  (lastmc),
        .go6     (go6),
        .halt    (halt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]      op;
        int unsigned     len;
        logic            g6;
        logic [4:1][2:0] cyc;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] mc;
        logic       first;
        logic       last;
        logic       g6;
        logic       hlt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   nstep = 0;
    vec_t vecs[20];

    function automatic vec_t mk(input logic [7:0] op, input int unsigned len, input logic g6,
                                input logic [2:0] c1, input logic [2:0] c2,
                                input logic [2:0] c3, input logic [2:0] c4);
        vec_t v;
        v.op     = op;
        v.len    = len;
        v.g6     = g6;
        v.cyc[1] = c1;
        v.cyc[2] = c2;
        v.cyc[3] = c3;
        v.cyc[4] = c4;
        return v;
    endfunction

    // One clock of stimulus; the expected outputs are queued before the edge
    // and popped for comparison once the DUT has registered its response.
    task automatic step(input string name, input logic rst, input logic ov, input logic [7:0] op,
                        input logic me, input logic rs,
                        input logic [2:0] e_st, input logic [2:0] e_mc,
                        input logic e_last, input logic e_g6, input logic e_hlt);
        exp_t e;
        exp_t a;
        e.st = e_st; e.mc = e_mc; e.first = (e_mc == 3'd0);
        e.last = e_last; e.g6 = e_g6; e.hlt = e_hlt;
        @(negedge clock);
        reset = rst; opvalid = ov; opcode = op; mcend = me; resume = rs;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        reset = 1'b0; opvalid = 1'b0; mcend = 1'b0; resume = 1'b0;
        a = '{st: status, mc: mcnum, first: firstmc, last: lastmc, g6: go6, hlt: halt};
        e = exp_q.pop_front();
        total++;
        nstep++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s step %0d: got st=%0d mc=%0d first=%0b last=%0b go6=%0b halt=%0b want st=%0d mc=%0d first=%0b last=%0b go6=%0b halt=%0b",
                     name, nstep, a.st, a.mc, a.first, a.last, a.g6, a.hlt,
                     e.st, e.mc, e.first, e.last, e.g6, e.hlt);
        end else begin
            $display("step %0d %s: st=%0d mc=%0d last=%0b go6=%0b halt=%0b ok",
                     nstep, name, a.st, a.mc, a.last, a.g6, a.hlt);
        end
    endtask

    initial begin
        vecs[0]  = mk(8'h3A, 4, 1'b0, MR, MR, MR, OF);
        vecs[1]  = mk(8'h32, 4, 1'b0, MR, MR, MW, OF);
        vecs[2]  = mk(8'h2A, 5, 1'b0, MR, MR, MR, MR);
        vecs[3]  = mk(8'h22, 5, 1'b0, MR, MR, MW, MW);
        vecs[4]  = mk(8'hCD, 5, 1'b1, MR, MR, MW, MW);
        vecs[5]  = mk(8'hC5, 3, 1'b1, MW, MW, OF, OF);
        vecs[6]  = mk(8'hDB, 3, 1'b0, MR, IR, OF, OF);
        vecs[7]  = mk(8'hD3, 3, 1'b0, MR, IW, OF, OF);
        vecs[8]  = mk(8'h09, 3, 1'b0, BI, BI, OF, OF);
        vecs[9]  = mk(8'h36, 3, 1'b0, MR, MW, OF, OF);
        vecs[10] = mk(8'h70, 2, 1'b0, MW, OF, OF, OF);
        vecs[11] = mk(8'h3E, 2, 1'b0, MR, OF, OF, OF);
        vecs[12] = mk(8'h86, 2, 1'b0, MR, OF, OF, OF);
        vecs[13] = mk(8'hC3, 3, 1'b0, MR, MR, OF, OF);
        vecs[14] = mk(8'hF1, 3, 1'b0, MR, MR, OF, OF);
        vecs[15] = mk(8'h23, 1, 1'b1, OF, OF, OF, OF);
        vecs[16] = mk(8'hF9, 1, 1'b1, OF, OF, OF, OF);
        vecs[17] = mk(8'hE9, 1, 1'b1, OF, OF, OF, OF);
        vecs[18] = mk(8'hC2, 1, 1'b0, OF, OF, OF, OF);
        vecs[19] = mk(8'h80, 1, 1'b0, OF, OF, OF, OF);

        // Reset state
        step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("reset2", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        // mcend before any opvalid behaves as a one-cycle instruction
        step("idle_mcend", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step("vec_of", 1'b0, 1'b1, vecs[i].op, 1'b0, 1'b0,
                 OF, 3'd0, (vecs[i].len == 1), vecs[i].g6, 1'b0);
            for (int k = 1; k < int'(vecs[i].len); k++) begin
                step("vec_mc", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0,
                     vecs[i].cyc[k], 3'(k), (k == int'(vecs[i].len) - 1), 1'b0, 1'b0);
            end
            step("vec_end", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // Reset during STA at mcnum=2
        step("sta_of", 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("sta_mc1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MR, 3'd1, 1'b0, 1'b0, 1'b0);
        step("sta_mc2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MR, 3'd2, 1'b0, 1'b0, 1'b0);
        step("sta_rst", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        // opvalid outside FETCH is ignored
        step("lda_of", 1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("lda_mc1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MR, 3'd1, 1'b0, 1'b0, 1'b0);
        step("exec_ov", 1'b0, 1'b1, 8'h76, 1'b0, 1'b0, MR, 3'd1, 1'b0, 1'b0, 1'b0);
        step("lda_mc2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MR, 3'd2, 1'b0, 1'b0, 1'b0);
        step("lda_mc3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MR, 3'd3, 1'b1, 1'b0, 1'b0);
        step("lda_end", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        // HLT entry, hold and resume
        step("hlt_of", 1'b0, 1'b1, 8'h76, 1'b0, 1'b0, OF, 3'd0, 1'b1, 1'b0, 1'b0);
        step("hlt_enter", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b1);
        step("hlt_mcend", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b1);
        step("hlt_opv", 1'b0, 1'b1, 8'hCD, 1'b0, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b1);
        step("hlt_resume", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("hlt_after", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        // HLT with opvalid and mcend together, then reset beats resume
        step("hlt_same", 1'b0, 1'b1, 8'h76, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b1);
        step("hlt_rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        // Same-clock opvalid and mcend
        step("mov_same", 1'b0, 1'b1, 8'h78, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("mvi_same", 1'b0, 1'b1, 8'h3E, 1'b1, 1'b0, MR, 3'd1, 1'b1, 1'b0, 1'b0);
        step("mvi_end", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("call_same", 1'b0, 1'b1, 8'hCD, 1'b1, 1'b0, MR, 3'd1, 1'b0, 1'b0, 1'b0);
        step("call_mc2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MR, 3'd2, 1'b0, 1'b0, 1'b0);
        step("call_mc3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MW, 3'd3, 1'b0, 1'b0, 1'b0);
        step("call_mc4", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, MW, 3'd4, 1'b1, 1'b0, 1'b0);
        step("call_end", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        // Second opvalid in FETCH overwrites the decode
        step("ovw_lda", 1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);
        step("ovw_push", 1'b0, 1'b1, 8'hC5, 1'b0, 1'b0, OF, 3'd0, 1'b0, 1'b1, 1'b0);
        step("ovw_mov", 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, OF, 3'd0, 1'b1, 1'b0, 1'b0);
        step("ovw_end", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, OF, 3'd0, 1'b0, 1'b0, 1'b0);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcycle_seq.md
# mcycle_seq

Machine-cycle sequencer for the 8085-compatible core. Decodes the opcode latched during each opcode fetch and steps through that instruction's machine cycles. For every cycle it drives the cycle-type code and the first/last/6-state/halt qualifiers consumed by the T-state machine. It sits between the instruction register and the T-state machine and owns the per-instruction bus-cycle schedule.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  8  instruction register contents; sampled only when opvalid=1.
- opvalid  in  1  one-clock pulse: opcode register loaded during the opcode-fetch cycle.
- mcend  in  1  one-clock pulse on the final T-state of the current machine cycle.
- resume  in  1  leave HALT (interrupt/reset-restart request); level, sampled each clock.
- status  out  3  current cycle type: 0 OF, 1 MR, 2 MW, 3 IOR, 4 IOW, 5 BI (bus idle); 6 and 7 never driven.
- mcnum  out  3  index of the current machine cycle, 0 = OF.
- firstmc  out  1  high when mcnum=0.
- lastmc  out  1  current cycle is the instruction's last.
- go6  out  1  current OF cycle is a 6-T-state fetch.
- halt  out  1  core is halted.

## Operation
- Controller states: FETCH (mcnum=0, waiting for or holding a decode), EXEC (mcnum≥1), HALT.
- Decode is combinational from opcode. It yields a length L (1–5) and a cycle list; the list is registered on opvalid.
- One-cycle group, L=1: all opcodes not listed below, including register MOV/ALU/INR/DCR, NOP, and conditional branches.
- 6-T-state group, OF only, go6=1: INX 00rr0011, DCX 00rr1011, SPHL F9, PCHL E9.
- MVI r 00ddd110 (ddd≠110), MOV r,M 01ddd110 (ddd≠110), ALU M 10xxx110, ALU imm 11xxx110: OF, MR.
- MOV M,r 01110sss (sss≠110): OF, MW.
- MVI M 36, INR M 34, DCR M 35: OF, MR, MW.
- LXI 00rr0001, JMP C3, RET C9, POP 11rr0001: OF, MR, MR.
- LDA 3A: OF, MR, MR, MR. STA 32: OF, MR, MR, MW.
- LHLD 2A: OF, MR, MR, MR, MR. SHLD 22: OF, MR, MR, MW, MW.
- CALL CD: OF with go6=1, then MR, MR, MW, MW.
- PUSH 11rr0101: OF with go6=1, then MW, MW.
- IN DB: OF, MR, IOR. OUT D3: OF, MR, IOW.
- DAD 00rr1001: OF, BI, BI.
- HLT 76: OF with L=1 and the halt flag set.
- FETCH + opvalid:
  - latch the decode;
  - go6 takes the opcode's 6-state flag;
  - lastmc = (L==1).
- mcend when lastmc=0:
  - mcnum increments;
  - status = list[mcnum];
  - lastmc = (new mcnum == L-1);
  - go6 = 0;
  - state becomes EXEC.
- mcend when lastmc=1:
  - if the halt flag is set, go to HALT: halt=1, status=OF, mcnum=0, lastmc=0, go6=0.
  - otherwise return to FETCH: mcnum=0, status=OF, lastmc=0, go6=0.
- HALT: ignores mcend and opvalid. When resume=1, clear halt and go to FETCH.
- mcend in FETCH before any opvalid: treat as an L=1 instruction and stay in FETCH.
- opvalid outside FETCH: ignored.
- opvalid and mcend in the same clock while in FETCH: the new decode is used for the end decision.
  - L=1: returns to FETCH.
  - Otherwise: advances to mcnum=1.
- A second opvalid in FETCH overwrites the decode.

## Timing
- All outputs are registered and update on the rising edge after the qualifying input.
- Decode latency: opvalid at edge n → go6/lastmc valid after edge n.
- Cycle advance: mcend at edge n → new status/mcnum after edge n. This is in place before the next cycle's T1.
- Reset values: status=0 (OF), mcnum=0, firstmc=1, lastmc=0, go6=0, halt=0, state FETCH, latched decode cleared to L=1.
- Reset mid-instruction: abandons the sequence at the next edge. No pending cycles are retained.
- reset has priority over resume, opvalid and mcend.

## Test plan
- Reset during an STA at mcnum=2 → next clock: status=0, mcnum=0, firstmc=1, lastmc=0, go6=0, halt=0.
- Opcode 3A (LDA), then 4 mcend pulses:
  - status steps 0, 1, 1, 1;
  - lastmc=1 only at mcnum=3;
  - the 4th mcend returns to mcnum=0.
- Opcode CD (CALL): go6=1 in OF; status sequence 0, 1, 1, 2, 2; go6=0 from mcnum=1 onward.
- Opcode DB (IN): status 0, 1, 3. Opcode D3 (OUT): status 0, 1, 4. Opcode 09 (DAD): status 0, 5, 5.
- Opcode 76 (HLT):
  - lastmc=1, then mcend gives halt=1;
  - further mcend/opvalid pulses leave it unchanged;
  - resume=1 gives halt=0 and FETCH, mcnum=0.
- Opcode 78 (MOV A,B) with opvalid and mcend in the same clock → stays in FETCH with mcnum=0.
- Opcode 3E (MVI A) with opvalid and mcend in the same clock → mcnum=1, status=1, lastmc=1.
